// File: rtl/moesi_pkg.sv
// Shared MOESI types and cache geometry helpers.
package moesi_pkg;

  typedef enum logic [2:0] {
    ST_I = 3'd0,
    ST_S = 3'd1,
    ST_E = 3'd2,
    ST_O = 3'd3,
    ST_M = 3'd4
  } moesi_e;

  typedef enum logic [1:0] {
    BUS_NONE = 2'b00,
    BUS_RD   = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_UPGR = 2'b11
  } bus_e;

  typedef enum logic [2:0] {
    F_IDLE,
    F_LOOKUP,
    F_EVAL,
    F_DATA,
    F_RESP
  } fsm_e;

  function automatic int set_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int aw, input int sets, input int lb);
    return aw - $clog2(sets) - $clog2(lb);
  endfunction

endpackage

// File: rtl/moesi_snoop_decode.sv
// Snoop transition table: bus op and current state to next state,
// data supply and hit.
module moesi_snoop_decode
  import moesi_pkg::*;
(
  input  bus_e   bus,
  input  moesi_e old_st,
  output moesi_e new_st,
  output logic   supply,
  output logic   hit
);

  logic owned;

  always_comb begin
    hit    = (old_st == ST_S) || (old_st == ST_E) ||
             (old_st == ST_O) || (old_st == ST_M);
    owned  = (old_st == ST_O) || (old_st == ST_M);
    new_st = old_st;
    supply = 1'b0;
    if (hit) begin
      case (bus)
        BUS_RD: begin
          supply = owned;
          new_st = owned ? ST_O : ST_S;
        end
        BUS_RDX: begin
          supply = owned;
          new_st = ST_I;
        end
        BUS_UPGR: begin
          new_st = ST_I;
        end
        default: begin
          new_st = old_st;
        end
      endcase
    end
  end

endmodule

// File: rtl/moesi_snoop_responder.sv
// Per-core snoop responder: probes tags, supplies dirty lines,
// and downgrades or invalidates the local copy.
module moesi_snoop_responder
  import moesi_pkg::*;
#(
  parameter int SETS       = 128,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_WIDTH = 64,
  localparam int DATA_WIDTH = LINE_BYTES * 8,
  localparam int SET_W = set_w(SETS),
  localparam int WAY_W = $clog2(WAYS),
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int TAG_W = tag_w(ADDR_WIDTH, SETS, LINE_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            core_id,
  input  logic                  snoop_valid,
  input  logic [1:0]            snoop_type,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  input  logic [1:0]            snoop_src_id,
  output logic                  snoop_ready,
  output logic                  lookup_req,
  output logic [SET_W-1:0]      lookup_set,
  output logic [TAG_W-1:0]      lookup_tag,
  input  logic                  lookup_hit,
  input  logic [WAY_W-1:0]      lookup_way,
  input  logic [2:0]            lookup_state,
  output logic                  data_rd_req,
  output logic [WAY_W-1:0]      data_rd_way,
  input  logic                  data_rd_valid,
  input  logic [DATA_WIDTH-1:0] data_rd_data,
  output logic                  upd_valid,
  output logic [WAY_W-1:0]      upd_way,
  output logic [2:0]            upd_state,
  output logic                  snoop_done,
  output logic                  snoop_hit,
  output logic                  snoop_dirty,
  output logic [DATA_WIDTH-1:0] snoop_data
);

  fsm_e   state, next;
  bus_e   type_q;
  moesi_e new_q, eff_st, dec_new;
  logic   dec_supply, dec_hit;
  logic   hit_q, dirty_q, upd_q, rd_done_q;
  logic   accept, self_snoop;

  logic [SET_W-1:0]      set_q;
  logic [TAG_W-1:0]      tag_q;
  logic [WAY_W-1:0]      way_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  addr_unused;

  assign addr_unused = ^snoop_addr[OFF_W-1:0];

  assign accept     = (state == F_IDLE) && snoop_valid &&
                      (snoop_type != BUS_NONE);
  assign self_snoop = (snoop_src_id == core_id);
  // A miss is decoded as an I line so the table yields no hit.
  assign eff_st     = lookup_hit ? moesi_e'(lookup_state) : ST_I;

  moesi_snoop_decode u_dec (
    .bus    (type_q),
    .old_st (eff_st),
    .new_st (dec_new),
    .supply (dec_supply),
    .hit    (dec_hit)
  );

  always_comb begin
    next = state;
    unique case (state)
      F_IDLE:   if (accept) next = self_snoop ? F_RESP : F_LOOKUP;
      F_LOOKUP: next = F_EVAL;
      F_EVAL:   next = dec_supply ? F_DATA : F_RESP;
      F_DATA:   if (data_rd_valid) next = F_RESP;
      F_RESP:   next = F_IDLE;
      default:  next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= F_IDLE;
      type_q    <= BUS_NONE;
      set_q     <= '0;
      tag_q     <= '0;
      way_q     <= '0;
      new_q     <= ST_I;
      hit_q     <= 1'b0;
      dirty_q   <= 1'b0;
      upd_q     <= 1'b0;
      rd_done_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state <= next;
      if (accept) begin
        type_q    <= bus_e'(snoop_type);
        set_q     <= snoop_addr[OFF_W +: SET_W];
        tag_q     <= snoop_addr[ADDR_WIDTH-1 -: TAG_W];
        hit_q     <= 1'b0;
        dirty_q   <= 1'b0;
        upd_q     <= 1'b0;
        rd_done_q <= 1'b0;
      end
      if (state == F_EVAL) begin
        way_q   <= lookup_way;
        new_q   <= dec_new;
        hit_q   <= dec_hit;
        dirty_q <= dec_supply;
        upd_q   <= dec_hit && (dec_new != eff_st);
      end
      if (state == F_DATA) begin
        rd_done_q <= 1'b1;
        if (data_rd_valid) data_q <= data_rd_data;
      end
    end
  end

  assign snoop_ready = (state == F_IDLE);
  assign lookup_req  = (state == F_LOOKUP);
  assign lookup_set  = set_q;
  assign lookup_tag  = tag_q;
  assign data_rd_req = (state == F_DATA) && !rd_done_q;
  assign data_rd_way = way_q;
  assign snoop_done  = (state == F_RESP);
  assign upd_valid   = snoop_done && upd_q;
  assign upd_way     = way_q;
  assign upd_state   = new_q;
  assign snoop_hit   = snoop_done && hit_q;
  assign snoop_dirty = snoop_done && dirty_q;
  assign snoop_data  = data_q;

endmodule

// File: tb/tb_moesi_snoop_responder.sv
// Directed bench for moesi_snoop_responder with default geometry.
module tb_moesi_snoop_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   core_id;
  logic         snoop_valid;
  logic [1:0]   snoop_type;
  logic [63:0]  snoop_addr;
  logic [1:0]   snoop_src_id;
  logic         snoop_ready;
  logic         lookup_req;
  logic [6:0]   lookup_set;
  logic [50:0]  lookup_tag;
  logic         lookup_hit;
  logic [1:0]   lookup_way;
  logic [2:0]   lookup_state;
  logic         data_rd_req;
  logic [1:0]   data_rd_way;
  logic         data_rd_valid;
  logic [511:0] data_rd_data;
  logic         upd_valid;
  logic [1:0]   upd_way;
  logic [2:0]   upd_state;
  logic         snoop_done;
  logic         snoop_hit;
  logic         snoop_dirty;
  logic [511:0] snoop_data;

  int vec = 0;
  int errs = 0;
  int n_done = 0;
  int n_upd = 0;
  int n_lkp = 0;
  int n_rd = 0;
  int d0, u0, l0, r0;
  logic [511:0] pat;

  moesi_snoop_responder dut (
    .clk           (clk),
    .rst           (rst),
    .core_id       (core_id),
    .snoop_valid   (snoop_valid),
    .snoop_type    (snoop_type),
    .snoop_addr    (snoop_addr),
    .snoop_src_id  (snoop_src_id),
    .snoop_ready   (snoop_ready),
    .lookup_req    (lookup_req),
    .lookup_set    (lookup_set),
    .lookup_tag    (lookup_tag),
    .lookup_hit    (lookup_hit),
    .lookup_way    (lookup_way),
    .lookup_state  (lookup_state),
    .data_rd_req   (data_rd_req),
    .data_rd_way   (data_rd_way),
    .data_rd_valid (data_rd_valid),
    .data_rd_data  (data_rd_data),
    .upd_valid     (upd_valid),
    .upd_way       (upd_way),
    .upd_state     (upd_state),
    .snoop_done    (snoop_done),
    .snoop_hit     (snoop_hit),
    .snoop_dirty   (snoop_dirty),
    .snoop_data    (snoop_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (snoop_done) n_done++;
    if (upd_valid) n_upd++;
    if (lookup_req) n_lkp++;
    if (data_rd_req) n_rd++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [1:0] src);
    snoop_valid  = 1'b1;
    snoop_type   = t;
    snoop_src_id = src;
    tick();
    snoop_valid  = 1'b0;
  endtask

  initial begin
    pat = {8{64'hDEAD_BEEF_0123_4567}};
    rst = 1'b1;
    core_id = 2'd0;
    snoop_valid = 1'b0;
    snoop_type = 2'b00;
    snoop_addr = 64'h0;
    snoop_src_id = 2'd0;
    lookup_hit = 1'b0;
    lookup_way = 2'd0;
    lookup_state = 3'd0;
    data_rd_valid = 1'b0;
    data_rd_data = '0;
    tick();
    tick();
    chk("rst_ready", snoop_ready, 1);
    chk("rst_done", snoop_done, 0);
    chk("rst_lookup", lookup_req, 0);
    chk("rst_upd", upd_valid, 0);
    chk("rst_data", snoop_data, 0);
    rst = 1'b0;
    tick();

    // BusRd to M line, way 1, read latency 2
    lookup_hit = 1'b1;
    lookup_way = 2'd1;
    lookup_state = 3'd4;
    snoop_addr = 64'h1040;
    chk("t1_ready", snoop_ready, 1);
    issue(2'b01, 2'd2);
    chk("t1_lkp", lookup_req, 1);
    chk("t1_set", lookup_set, 7'h41);
    chk("t1_tag", lookup_tag, 0);
    tick();
    chk("t1_lkp_off", lookup_req, 0);
    tick();
    chk("t1_rdreq", data_rd_req, 1);
    chk("t1_rdway", data_rd_way, 1);
    tick();
    chk("t1_rdreq_once", data_rd_req, 0);
    snoop_valid = 1'b1;
    snoop_type = 2'b10;
    snoop_src_id = 2'd1;
    chk("t1_busy", snoop_ready, 0);
    tick();
    chk("t1_done_early", snoop_done, 0);
    data_rd_valid = 1'b1;
    data_rd_data = pat;
    tick();
    data_rd_valid = 1'b0;
    snoop_valid = 1'b0;
    chk("t1_done", snoop_done, 1);
    chk("t1_hit", snoop_hit, 1);
    chk("t1_dirty", snoop_dirty, 1);
    chk("t1_data", snoop_data, pat);
    chk("t1_upd", upd_valid, 1);
    chk("t1_updway", upd_way, 1);
    chk("t1_updst", upd_state, 3);
    tick();
    chk("t1_done_off", snoop_done, 0);
    chk("t1_idle", snoop_ready, 1);
    d0 = n_done;
    tick();
    tick();
    tick();
    chk("t1_ignored", n_done - d0, 0);

    // BusRdX to E line, way 2
    lookup_way = 2'd2;
    lookup_state = 3'd2;
    r0 = n_rd;
    issue(2'b10, 2'd1);
    tick();
    chk("t2_done_early", snoop_done, 0);
    tick();
    chk("t2_done", snoop_done, 1);
    chk("t2_hit", snoop_hit, 1);
    chk("t2_dirty", snoop_dirty, 0);
    chk("t2_upd", upd_valid, 1);
    chk("t2_updst", upd_state, 0);
    chk("t2_updway", upd_way, 2);
    tick();
    chk("t2_no_rd", n_rd - r0, 0);

    // BusUpgr to O line
    lookup_way = 2'd0;
    lookup_state = 3'd3;
    issue(2'b11, 2'd3);
    tick();
    tick();
    chk("t3_done", snoop_done, 1);
    chk("t3_hit", snoop_hit, 1);
    chk("t3_dirty", snoop_dirty, 0);
    chk("t3_upd", upd_valid, 1);
    chk("t3_updst", upd_state, 0);
    tick();

    // BusRd to S line
    lookup_state = 3'd1;
    issue(2'b01, 2'd1);
    tick();
    tick();
    chk("t4_done", snoop_done, 1);
    chk("t4_hit", snoop_hit, 1);
    chk("t4_noupd", upd_valid, 0);
    chk("t4_dirty", snoop_dirty, 0);
    tick();

    // tag miss with stale M state on the bus
    lookup_hit = 1'b0;
    lookup_state = 3'd4;
    issue(2'b10, 2'd1);
    tick();
    tick();
    chk("t5_done", snoop_done, 1);
    chk("t5_hit", snoop_hit, 0);
    chk("t5_noupd", upd_valid, 0);
    chk("t5_dirty", snoop_dirty, 0);
    tick();

    // illegal state encoding 6
    lookup_hit = 1'b1;
    lookup_state = 3'd6;
    issue(2'b01, 2'd1);
    tick();
    tick();
    chk("t6_done", snoop_done, 1);
    chk("t6_hit", snoop_hit, 0);
    chk("t6_noupd", upd_valid, 0);
    tick();

    // self snoop
    lookup_state = 3'd4;
    l0 = n_lkp;
    issue(2'b10, 2'd0);
    chk("t7_done", snoop_done, 1);
    chk("t7_hit", snoop_hit, 0);
    chk("t7_dirty", snoop_dirty, 0);
    chk("t7_noupd", upd_valid, 0);
    tick();
    chk("t7_nolkp", n_lkp - l0, 0);
    chk("t7_idle", snoop_ready, 1);

    // type 00 never accepted
    d0 = n_done;
    snoop_valid = 1'b1;
    snoop_type = 2'b00;
    snoop_src_id = 2'd1;
    tick();
    chk("t8_ready", snoop_ready, 1);
    tick();
    tick();
    snoop_valid = 1'b0;
    chk("t8_nodone", n_done - d0, 0);

    // reset while waiting for read data
    lookup_state = 3'd4;
    issue(2'b01, 2'd1);
    tick();
    tick();
    chk("t9_rdreq", data_rd_req, 1);
    tick();
    d0 = n_done;
    u0 = n_upd;
    #2;
    rst = 1'b1;
    #1;
    chk("t9_ready", snoop_ready, 1);
    chk("t9_rdreq_off", data_rd_req, 0);
    chk("t9_set", lookup_set, 0);
    tick();
    rst = 1'b0;
    data_rd_valid = 1'b1;
    data_rd_data = pat;
    tick();
    data_rd_valid = 1'b0;
    tick();
    tick();
    chk("t9_nodone", n_done - d0, 0);
    chk("t9_noupd", n_upd - u0, 0);
    chk("t9_idle", snoop_ready, 1);
    chk("t9_data", snoop_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
